cpu_req_arbiter: RTL

Shares one cpu datapath instance among NUM_REQ requesters. The cpu is a 16-bit instruction-in/result-out stream core.
- Round-robin arbitration picks one pending instruction and issues it on the cpu slave stream.
- The block waits for the cpu result stream, then returns the result to the granted requester.
- Exactly one instruction is in flight at a time. The block sits between the requester fabric and the cpu's slave and master stream ports.

---
 rtl/cpu_req_arbiter_pkg.sv | 19 +
 rtl/cpu_req_arbiter_rr_pick.sv | 30 +++
 rtl/cpu_req_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cpu_req_arbiter_pkg.sv
// Shared encodings and defaults for the cpu request arbiter.
package cpu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_RETURN    = 2'd3
    } arb_state_t;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_ID_W           = 2;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // Wide all-ones pattern, truncated to DATA_WIDTH where used as the error result.
    localparam logic [63:0] ERR_RESULT = '1;

endpackage

// File: rtl/cpu_req_arbiter_rr_pick.sv
// Round-robin picker: first asserted req_i at or above ptr_i, wrapping modulo NUM_REQ.
// Purely combinational, zero latency.
module rr_pick
    import cpu_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    winner_o,
    output logic               any_valid_o
);

    logic [ID_W-1:0] idx;

    always_comb begin
        winner_o    = '0;
        any_valid_o = 1'b0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!any_valid_o && req_i[idx]) begin
                winner_o    = idx;
                any_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_req_arbiter.sv
// Shares one cpu stream core among NUM_REQ requesters, one instruction in flight; accept->rsp_tvalid 3 cycles with zero-wait cpu.
// Stalls on cpu_tready/res_tvalid/rsp_tready; CPU_ARB_TIMEOUT_EN adds a WAIT_RESP watchdog and the timeout_err port.
module cpu_req_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ID_W           = DEF_ID_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_tvalid,
    output logic [NUM_REQ-1:0]            req_tready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata,
    output logic                          cpu_tvalid,
    input  logic                          cpu_tready,
    output logic [DATA_WIDTH-1:0]         cpu_tdata,
    input  logic                          res_tvalid,
    output logic                          res_tready,
    input  logic [DATA_WIDTH-1:0]         res_tdata,
    output logic [NUM_REQ-1:0]            rsp_tvalid,
    input  logic [NUM_REQ-1:0]            rsp_tready,
    output logic [DATA_WIDTH-1:0]         rsp_tdata,
    output logic [ID_W-1:0]               grant_id,
`ifdef CPU_ARB_TIMEOUT_EN
    output logic                          timeout_err,
`endif
    output logic                          busy
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("cpu_req_arbiter: illegal parameter combination");
    end

    arb_state_t            state_q, state_d;
    logic [ID_W-1:0]       rr_q, rr_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  cpu_vld_q, cpu_vld_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic [ID_W-1:0]       win;
    logic                  any_vld;
    logic [DATA_WIDTH-1:0] req_slice [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign req_slice[i] = req_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_i       (req_tvalid),
        .ptr_i       (rr_q),
        .winner_o    (win),
        .any_valid_o (any_vld)
    );

`ifdef CPU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
`endif

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        instr_d   = instr_q;
        cpu_vld_d = cpu_vld_q;
        rsp_dat_d = rsp_dat_q;
`ifdef CPU_ARB_TIMEOUT_EN
        cnt_d     = '0;
        to_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_vld) begin
                    instr_d   = req_slice[win];
                    grant_d   = win;
                    cpu_vld_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cpu_tready) begin
                    cpu_vld_d = 1'b0;
                    state_d   = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (res_tvalid) begin
                    rsp_dat_d = res_tdata;
                    state_d   = ST_RETURN;
                end
`ifdef CPU_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_dat_d = DATA_WIDTH'(ERR_RESULT);
                    to_d      = 1'b1;
                    state_d   = ST_RETURN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RETURN: begin
                // Only the granted line's ready completes the transfer.
                if (rsp_tready[grant_q]) begin
                    rr_d    = ID_W'((int'(grant_q) + 1) % NUM_REQ);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_q      <= '0;
            grant_q   <= '0;
            instr_q   <= '0;
            cpu_vld_q <= 1'b0;
            rsp_dat_q <= '0;
`ifdef CPU_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            to_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            instr_q   <= instr_d;
            cpu_vld_q <= cpu_vld_d;
            rsp_dat_q <= rsp_dat_d;
`ifdef CPU_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            to_q      <= to_d;
`endif
        end
    end

    assign req_tready = (state_q == ST_IDLE && any_vld) ? (NUM_REQ'(1) << win) : '0;
    assign rsp_tvalid = (state_q == ST_RETURN) ? (NUM_REQ'(1) << grant_q) : '0;
    assign cpu_tvalid = cpu_vld_q;
    assign cpu_tdata  = instr_q;
    assign rsp_tdata  = rsp_dat_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q != ST_IDLE);

`ifdef CPU_ARB_TIMEOUT_EN
    // Idle also drains a result that arrives after its transaction timed out.
    assign res_tready  = (state_q == ST_WAIT_RESP) || (state_q == ST_IDLE);
    assign timeout_err = to_q;
`else
    assign res_tready  = (state_q == ST_WAIT_RESP);
`endif

endmodule
